// File: rtl/hv_sram_server_pkg.sv
// Shared definitions for the hypervector SRAM server.
// Holds the host write bank-select codes and the default geometry:
// DIM matches the encoder's hypervector width, DEPTH the channel count of
// the largest modality, AW the encoder's SRAM address width.
package hv_sram_server_pkg;

  localparam int DIM_DEFAULT   = 2000;
  localparam int DEPTH_DEFAULT = 214;
  localparam int AW_DEFAULT    = 8;

  typedef enum logic [1:0] {
    BANK_IM   = 2'd0,
    BANK_NEG  = 2'd1,
    BANK_POS  = 2'd2,
    BANK_NONE = 2'd3
  } bank_e;

endpackage

// File: rtl/hv_sram_bank.sv
// Behavioural single-port DEPTH x DIM row bank with a 1-cycle synchronous
// read. Drop-in point for an SRAM macro. A write takes precedence over a
// read in the same cycle; rdata holds its value when no read is issued.
// Ports:
//   clk    - clock
//   we     - write enable (row at addr <= wdata)
//   re     - read enable (rdata <= row at addr on the next edge)
//   addr   - shared read/write row address
//   wdata  - write data
//   rdata  - registered read data
module hv_sram_bank
  import hv_sram_server_pkg::*;
#(
  parameter int DIM   = DIM_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = AW_DEFAULT
) (
  input  logic           clk,
  input  logic           we,
  input  logic           re,
  input  logic [AW-1:0]  addr,
  input  logic [DIM-1:0] wdata,
  output logic [DIM-1:0] rdata
);

  logic [DIM-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/hv_sram_server.sv
// Responder for one modality of the spatial encoder's SRAM interface.
// Serves row triples (iM, projM_neg, projM_pos) for the requested address
// through a two-entry prefetch buffer plus an in-flight bypass, so a cold
// miss answers one cycle later and a streaming encoder gets one row/cycle.
// Ports:
//   Clk_CI, Reset_RBI          - clock, asynchronous active-low reset
//   Req_SI, Addr_DI            - encoder request level and row address
//   Valid{IM,Neg,Pos}_SO       - row for Addr_DI is being presented
//   IMOut_DO, ProjNegOut_DO,
//   ProjPosOut_DO              - row data
//   WrEn_SI, WrBank_SI,
//   WrAddr_DI, WrData_DI       - host bank write port
//   WrReady_SO                 - constant 1, writes never stall
module hv_sram_server
  import hv_sram_server_pkg::*;
#(
  parameter int DIM   = DIM_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = AW_DEFAULT
) (
  input  logic           Clk_CI,
  input  logic           Reset_RBI,
  input  logic           Req_SI,
  input  logic [AW-1:0]  Addr_DI,
  output logic           ValidIM_SO,
  output logic           ValidNeg_SO,
  output logic           ValidPos_SO,
  output logic [DIM-1:0] IMOut_DO,
  output logic [DIM-1:0] ProjNegOut_DO,
  output logic [DIM-1:0] ProjPosOut_DO,
  input  logic           WrEn_SI,
  input  logic [1:0]     WrBank_SI,
  input  logic [AW-1:0]  WrAddr_DI,
  input  logic [DIM-1:0] WrData_DI,
  output logic           WrReady_SO
);

  localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];
  localparam logic [AW:0] ONE_V   = {{AW{1'b0}}, 1'b1};

  // Buffer entries and the in-flight read tag.
  logic [1:0]     e_vld;
  logic [AW-1:0]  e_tag [2];
  logic [DIM-1:0] e_im  [2];
  logic [DIM-1:0] e_neg [2];
  logic [DIM-1:0] e_pos [2];
  logic           if_vld;
  logic [AW-1:0]  if_tag;

  logic [DIM-1:0] rd_im, rd_neg, rd_pos;
  logic           in_range, nxt_ok;
  logic [AW:0]    addr_nxt;
  logic [1:0]     hit_e, cur_in_e, nxt_in_e, fill_ok, inv;
  logic           hit_f, hit;
  logic           cur_fly, nxt_fly;
  logic           rd_en;
  logic [AW-1:0]  rd_addr, bank_addr;
  logic           wr_eff;
  logic [2:0]     bank_we;
  logic           fill_en, fill_sel;

  // Address arithmetic is one bit wider so DEPTH-1 never wraps to row 0.
  assign in_range = {1'b0, Addr_DI} < DEPTH_V;
  assign addr_nxt = {1'b0, Addr_DI} + ONE_V;
  assign nxt_ok   = addr_nxt < DEPTH_V;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cur_in_e[i] = e_vld[i] && (e_tag[i] == Addr_DI);
      nxt_in_e[i] = e_vld[i] && (e_tag[i] == addr_nxt[AW-1:0]);
      hit_e[i]    = Req_SI && in_range && cur_in_e[i];
      fill_ok[i]  = !cur_in_e[i];
      inv[i]      = wr_eff && e_vld[i] && (e_tag[i] == WrAddr_DI);
    end
  end

  assign cur_fly = if_vld && (if_tag == Addr_DI);
  assign nxt_fly = if_vld && (if_tag == addr_nxt[AW-1:0]);

  // The row read last cycle is presented straight from the bank output,
  // which is what gives a cold miss its single-cycle latency.
  assign hit_f = Req_SI && in_range && cur_fly;
  assign hit   = hit_e[0] || hit_e[1] || hit_f;

  assign ValidIM_SO  = hit;
  assign ValidNeg_SO = hit;
  assign ValidPos_SO = hit;
  assign WrReady_SO  = 1'b1;

  always_comb begin
    IMOut_DO      = e_im[0];
    ProjNegOut_DO = e_neg[0];
    ProjPosOut_DO = e_pos[0];
    if (hit_e[0]) begin
      IMOut_DO      = e_im[0];
      ProjNegOut_DO = e_neg[0];
      ProjPosOut_DO = e_pos[0];
    end else if (hit_e[1]) begin
      IMOut_DO      = e_im[1];
      ProjNegOut_DO = e_neg[1];
      ProjPosOut_DO = e_pos[1];
    end else if (hit_f) begin
      IMOut_DO      = rd_im;
      ProjNegOut_DO = rd_neg;
      ProjPosOut_DO = rd_pos;
    end
  end

  // Issue arbiter: host writes own the single bank port; otherwise fetch
  // the requested row, else prefetch the next one.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = Addr_DI;
    if (!WrEn_SI && Req_SI && in_range) begin
      if (!(cur_in_e[0] || cur_in_e[1]) && !cur_fly) begin
        rd_en = 1'b1;
      end else if (nxt_ok && !(nxt_in_e[0] || nxt_in_e[1]) && !nxt_fly) begin
        rd_en   = 1'b1;
        rd_addr = addr_nxt[AW-1:0];
      end
    end
  end

  assign wr_eff     = WrEn_SI && (WrBank_SI != BANK_NONE) && ({1'b0, WrAddr_DI} < DEPTH_V);
  assign bank_we[0] = wr_eff && (WrBank_SI == BANK_IM);
  assign bank_we[1] = wr_eff && (WrBank_SI == BANK_NEG);
  assign bank_we[2] = wr_eff && (WrBank_SI == BANK_POS);
  assign bank_addr  = WrEn_SI ? WrAddr_DI : rd_addr;

  // Fill never targets the entry holding the current address, so a hit
  // entry survives. A write to the in-flight row makes its data stale.
  always_comb begin
    fill_en  = if_vld && !(wr_eff && (WrAddr_DI == if_tag)) && (fill_ok != 2'b00);
    fill_sel = (fill_ok == 2'b11) ? (e_vld[0] && !e_vld[1]) : !fill_ok[0];
  end

  always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
    if (!Reset_RBI) begin
      e_vld  <= '0;
      if_vld <= 1'b0;
      if_tag <= '0;
      for (int i = 0; i < 2; i++) begin
        e_tag[i] <= '0;
        e_im[i]  <= '0;
        e_neg[i] <= '0;
        e_pos[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (inv[i]) e_vld[i] <= 1'b0;
      end
      if (fill_en) begin
        e_vld[fill_sel] <= 1'b1;
        e_tag[fill_sel] <= if_tag;
        e_im[fill_sel]  <= rd_im;
        e_neg[fill_sel] <= rd_neg;
        e_pos[fill_sel] <= rd_pos;
      end
      if_vld <= rd_en;
      if_tag <= rd_addr;
    end
  end

  hv_sram_bank #(.DIM(DIM), .DEPTH(DEPTH), .AW(AW)) u_bank_im (
    .clk(Clk_CI), .we(bank_we[0]), .re(rd_en), .addr(bank_addr),
    .wdata(WrData_DI), .rdata(rd_im)
  );

  hv_sram_bank #(.DIM(DIM), .DEPTH(DEPTH), .AW(AW)) u_bank_neg (
    .clk(Clk_CI), .we(bank_we[1]), .re(rd_en), .addr(bank_addr),
    .wdata(WrData_DI), .rdata(rd_neg)
  );

  hv_sram_bank #(.DIM(DIM), .DEPTH(DEPTH), .AW(AW)) u_bank_pos (
    .clk(Clk_CI), .we(bank_we[2]), .re(rd_en), .addr(bank_addr),
    .wdata(WrData_DI), .rdata(rd_pos)
  );

endmodule

// File: tb/tb_hv_sram_server.sv
// Self-checking bench for hv_sram_server: directed scenarios (cold stream,
// last row, counter wrap, stall, out-of-range, write coherence, reset) and a
// randomized phase, checked against a row-array model of the three banks.
module tb_hv_sram_server;
  import hv_sram_server_pkg::*;

  localparam int DIM   = DIM_DEFAULT;
  localparam int DEPTH = DEPTH_DEFAULT;
  localparam int AW    = AW_DEFAULT;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req, wr_en;
  logic [AW-1:0]  addr, wr_addr;
  logic [1:0]     wr_bank;
  logic [DIM-1:0] wr_data;
  logic           vld_im, vld_neg, vld_pos, wr_ready;
  logic [DIM-1:0] im_out, neg_out, pos_out;

  hv_sram_server #(.DIM(DIM), .DEPTH(DEPTH), .AW(AW)) dut (
    .Clk_CI(clk), .Reset_RBI(rst_n), .Req_SI(req), .Addr_DI(addr),
    .ValidIM_SO(vld_im), .ValidNeg_SO(vld_neg), .ValidPos_SO(vld_pos),
    .IMOut_DO(im_out), .ProjNegOut_DO(neg_out), .ProjPosOut_DO(pos_out),
    .WrEn_SI(wr_en), .WrBank_SI(wr_bank), .WrAddr_DI(wr_addr),
    .WrData_DI(wr_data), .WrReady_SO(wr_ready)
  );

  always #5 clk = ~clk;

  // Reference contents of the three banks.
  logic [DIM-1:0] m_im [DEPTH];
  logic [DIM-1:0] m_neg[DEPTH];
  logic [DIM-1:0] m_pos[DEPTH];

  int errors = 0;
  int checks = 0;

  // Previous-cycle request, for the "one cycle to Valid" rule.
  logic          p_ok;
  logic [AW-1:0] p_addr;
  // Values sampled in the last step.
  logic           s_rd;
  logic [DIM-1:0] s_pos;

  task automatic chk(input string tag, input logic [DIM-1:0] got, input logic [DIM-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (low 64 bits)", tag, got[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [DIM-1:0] rnd_row();
    logic [DIM-1:0] r;
    r = '0;
    for (int i = 0; i < DIM; i += 16) r[i +: 16] = 16'($urandom);
    return r;
  endfunction

  // One clock cycle: drive at posedge+1, check at negedge, return at posedge+1.
  task automatic step(input logic rq, input logic [AW-1:0] ad, input logic we,
                      input logic [1:0] wb, input logic [AW-1:0] wa,
                      input logic [DIM-1:0] wd, output logic v);
    logic in_rng;
    req = rq; addr = ad; wr_en = we; wr_bank = wb; wr_addr = wa; wr_data = wd;
    @(negedge clk);
    v      = vld_im;
    s_rd   = dut.rd_en;
    s_pos  = pos_out;
    in_rng = int'(ad) < DEPTH;
    chk("vld_neg_eq", DIM'(vld_neg), DIM'(v));
    chk("vld_pos_eq", DIM'(vld_pos), DIM'(v));
    if (!rq || !in_rng) chk("vld_off", DIM'(v), DIM'(0));
    if (we || !rq || !in_rng) chk("no_read", DIM'(s_rd), DIM'(0));
    if (rq && in_rng && p_ok && p_addr == ad) chk("vld_latency", DIM'(v), DIM'(1));
    if (v && in_rng) begin
      chk("im_data", im_out, m_im[ad]);
      chk("neg_data", neg_out, m_neg[ad]);
      chk("pos_data", pos_out, m_pos[ad]);
    end
    p_ok   = rq && in_rng && !we;
    p_addr = ad;
    if (we && wb != 2'd3 && int'(wa) < DEPTH) begin
      case (wb)
        2'd0:    m_im[wa]  = wd;
        2'd1:    m_neg[wa] = wd;
        default: m_pos[wa] = wd;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic           v;
    logic [DIM-1:0] z, pat;
    int             acc, cyc, a, n, r;
    logic           rq, wen;
    logic [1:0]     wb;
    logic [AW-1:0]  wa;

    z = '0;
    pat = {250{8'hA5}};
    rst_n = 1'b0; req = 1'b0; addr = '0; wr_en = 1'b0; wr_bank = '0;
    wr_addr = '0; wr_data = '0; p_ok = 1'b0; p_addr = '0; s_rd = 1'b0; s_pos = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld_im", DIM'(vld_im), DIM'(0));
    chk("rst_vld_neg", DIM'(vld_neg), DIM'(0));
    chk("rst_vld_pos", DIM'(vld_pos), DIM'(0));
    chk("rst_im", im_out, z);
    chk("rst_neg", neg_out, z);
    chk("rst_pos", pos_out, z);
    chk("rst_wr_ready", DIM'(wr_ready), DIM'(1));
    rst_n = 1'b1;

    // Load all three banks, plus an ignored bank-3 write.
    for (int row = 0; row < DEPTH; row++)
      for (int b = 0; b < 3; b++)
        step(1'b0, '0, 1'b1, 2'(b), AW'(row), rnd_row(), v);
    step(1'b0, '0, 1'b1, 2'd3, AW'(10), rnd_row(), v);
    chk("wr_ready_load", DIM'(wr_ready), DIM'(1));

    // Cold stream 0..DEPTH-1, advancing on Valid.
    acc = 0; cyc = 0;
    while (acc < DEPTH && cyc < 400) begin
      step(1'b1, AW'(acc), 1'b0, 2'd0, '0, z, v);
      chk("stream_vld", DIM'(v), DIM'(cyc == 0 ? 0 : 1));
      if (v && acc == DEPTH - 1) chk("last_no_prefetch", DIM'(s_rd), DIM'(0));
      if (v) acc++;
      cyc++;
    end
    chk("stream_rows", DIM'(acc), DIM'(DEPTH));
    chk("stream_cycles", DIM'(cyc), DIM'(DEPTH + 1));

    // Counter wrap back to row 0: one bubble then data.
    step(1'b1, '0, 1'b0, 2'd0, '0, z, v);
    chk("wrap_bubble", DIM'(v), DIM'(0));
    step(1'b1, '0, 1'b0, 2'd0, '0, z, v);
    chk("wrap_row0", DIM'(v), DIM'(1));

    a = 1; n = 0;
    while (a < 11 && n < 40) begin
      step(1'b1, AW'(a), 1'b0, 2'd0, '0, z, v);
      if (v) a++;
      n++;
    end
    chk("reach_row10", DIM'(a), DIM'(11));

    // Stall with Req low on row 10.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, AW'(10), 1'b0, 2'd0, '0, z, v);
      chk("stall_vld", DIM'(v), DIM'(0));
      chk("stall_no_read", DIM'(s_rd), DIM'(0));
    end
    step(1'b1, AW'(10), 1'b0, 2'd0, '0, z, v);
    chk("resume_hit", DIM'(v), DIM'(1));

    // Write coherence on row 5 while it is buffered.
    step(1'b1, AW'(4), 1'b0, 2'd0, '0, z, v);
    step(1'b1, AW'(4), 1'b0, 2'd0, '0, z, v);
    chk("row4_vld", DIM'(v), DIM'(1));
    step(1'b1, AW'(5), 1'b0, 2'd0, '0, z, v);
    chk("row5_prefetched", DIM'(v), DIM'(1));
    step(1'b1, AW'(5), 1'b0, 2'd0, '0, z, v);
    chk("row5_buffered", DIM'(v), DIM'(1));
    step(1'b1, AW'(5), 1'b1, BANK_POS, AW'(5), pat, v);
    chk("coh_write_cycle", DIM'(v), DIM'(1));
    step(1'b1, AW'(5), 1'b0, 2'd0, '0, z, v);
    chk("coh_invalidated", DIM'(v), DIM'(0));
    step(1'b1, AW'(5), 1'b0, 2'd0, '0, z, v);
    chk("coh_refetched", DIM'(v), DIM'(1));
    chk("coh_pattern", s_pos, pat);

    // Out-of-range addresses never become valid.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, AW'(220), 1'b0, 2'd0, '0, z, v);
      chk("oor220_vld", DIM'(v), DIM'(0));
    end
    step(1'b1, AW'(DEPTH), 1'b0, 2'd0, '0, z, v);
    chk("oor_depth_vld", DIM'(v), DIM'(0));

    // Asynchronous reset mid-stream.
    step(1'b1, AW'(30), 1'b0, 2'd0, '0, z, v);
    step(1'b1, AW'(30), 1'b0, 2'd0, '0, z, v);
    step(1'b1, AW'(31), 1'b0, 2'd0, '0, z, v);
    chk("pre_rst_row31", DIM'(v), DIM'(1));
    #2;
    chk("pre_rst_hold", DIM'(vld_im), DIM'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_async_vld", DIM'(vld_im), DIM'(0));
    chk("rst_async_data", im_out, z);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    p_ok = 1'b0;
    step(1'b1, AW'(31), 1'b0, 2'd0, '0, z, v);
    chk("post_rst_cold", DIM'(v), DIM'(0));
    step(1'b1, AW'(31), 1'b0, 2'd0, '0, z, v);
    chk("post_rst_vld", DIM'(v), DIM'(1));

    // Randomized traffic with interleaved host writes.
    a = 32;
    for (int k = 0; k < 500; k++) begin
      r   = int'($urandom_range(0, 99));
      rq  = (r < 88);
      wen = ($urandom_range(0, 11) == 0);
      wb  = 2'($urandom_range(0, 3));
      wa  = ($urandom_range(0, 1) == 1) ? AW'(a) : AW'($urandom_range(0, DEPTH + 5));
      if (r >= 96) a = int'($urandom_range(0, 255));
      step(rq, AW'(a), wen, wb, wa, rnd_row(), v);
      if (v) a = (a + 1 < DEPTH) ? a + 1 : 0;
      else if (a >= DEPTH && $urandom_range(0, 3) == 0) a = int'($urandom_range(0, DEPTH - 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hv_sram_server.md
# hv_sram_server

Responder side of the spatial encoder's SRAM interface, serving one modality. It holds three row banks: item memory (iM), negative projection matrix (projM_neg) and positive projection matrix (projM_pos). It answers the encoder's per-modality ready/address request with the three hypervector rows and level-valid flags. A two-entry prefetch buffer sustains one channel per cycle. The design instantiates one server per modality (three total); a host write port loads the banks before encoding.

## Interface
- `DIM`, default 2000: hypervector width (`HV_DIMENSION`).
- `DEPTH`, default 214: rows per bank (channels of this modality).
- `AW`, default 8: address width (matches the encoder's `sram_addr`).

- `Clk_CI` input, 1: clock.
- `Reset_RBI` input, 1: asynchronous, active-low reset.
- `Req_SI` input, 1: encoder `spatial_ready_k` for this modality.
- `Addr_DI` input, AW: encoder `sram_addr`, the row requested this cycle.
- `ValidIM_SO`, `ValidNeg_SO`, `ValidPos_SO` output, 1 each: row for `Addr_DI` is present. All three are always equal.
- `IMOut_DO`, `ProjNegOut_DO`, `ProjPosOut_DO` output, DIM each: row data.
- `WrEn_SI` input, 1: host write strobe.
- `WrBank_SI` input, 2: bank select; 0 = iM, 1 = projM_neg, 2 = projM_pos, 3 = ignored.
- `WrAddr_DI` input, AW: write row.
- `WrData_DI` input, DIM: write data.
- `WrReady_SO` output, 1: always 1. Writes are never stalled.

## Operation
- Banks are single-port with 1-cycle synchronous read. All three banks share one read address and enable, so a read returns a full triple.
- The buffer has entries E0 and E1, each holding a valid bit, a tag (AW bits) and a row triple (3×DIM bits). There is also an in-flight register holding a valid bit and a tag for a read issued last cycle.
- Hit: `Req_SI` = 1, `Addr_DI` < DEPTH, and a valid entry's tag equals `Addr_DI`.
  - On a hit, all Valid outputs = 1 and the data outputs are driven from the hitting entry.
  - Otherwise Valid = 0 and the data outputs hold the E0 contents (don't-care for the encoder).
- Read issue, evaluated each cycle in priority order:
  1. `WrEn_SI` = 1: perform the write and issue no read.
  2. `Req_SI` = 0, or `Addr_DI` ≥ DEPTH: issue no read.
  3. `Addr_DI` is not buffered and not in flight: read `Addr_DI`.
  4. Else, `Addr_DI`+1 < DEPTH and `Addr_DI`+1 is not buffered and not in flight: prefetch `Addr_DI`+1.
  5. Else: idle.
- Fill: in-flight data is written into the entry whose tag ≠ the current `Addr_DI`. If both entries qualify, the invalid one is chosen; otherwise E0.
  - The entry currently hit on is never overwritten.
- Write coherence: a write to row r clears the valid bit of any entry with tag r. If r is in flight, its fill is dropped.
- Address arithmetic: `Addr_DI`+1 is computed in AW+1 bits. There is no wrap; at the last row (DEPTH−1) no prefetch is issued.
- The encoder clears its counter to 0 after the last channel. A request for row 0 then takes the normal miss path.

## Timing
- Reset (asynchronous assert, synchronous release): entries invalid, in-flight invalid, Valid outputs 0, data outputs 0, `WrReady_SO` = 1.
- Reset mid-burst drops all buffered and in-flight rows. Bank contents are unaffected.
- Cold miss: address presented in cycle t gives Valid = 1 in cycle t+1.
- Streaming: while Valid = 1 for row a, row a+1 is prefetched in the same cycle. If the encoder advances at the end of that cycle, row a+1 hits with zero bubble. Sustained throughput is 1 row/cycle.
- Valid is level-based and combinational from `Addr_DI`/`Req_SI` plus registered state. It never depends on `WrEn_SI` in the same cycle, except through invalidation at the next edge.
- When `Req_SI` drops, Valid drops in the same cycle and the buffer contents are retained.

## Structure
- A shared package/header holds the bank-select codes (`BANK_IM`, `BANK_NEG`, `BANK_POS`) and the default DIM/DEPTH/AW values, consistent with `HV_DIMENSION` and the modality channel counts.
- Sub-module `hv_sram_bank`: a behavioural single-port DEPTH×DIM bank with 1-cycle read, instantiated three times. It is the swap point for an SRAM macro.
- The server contains the tag/buffer logic, the issue arbiter and the output mux.

## Test plan
- Cold stream: after loading rows 0..213 with distinct patterns, hold `Req_SI` = 1 and advance `Addr_DI` 0→213 whenever Valid is seen. Required: Valid first in cycle 1, then on every cycle; 214 rows accepted in 215 cycles; data matches the loaded rows.
- Last row: `Addr_DI` = 213 hit. Required: no prefetch issued (bank enable low), and no out-of-range read.
- Counter wrap: after 213, `Addr_DI` returns to 0. Required: exactly one Valid = 0 bubble, then row 0 data.
- Coherence: while row 5 is buffered, write projM_pos[5] = 0xA5 pattern with `Addr_DI` = 5. Required: Valid = 1 in the write cycle, Valid = 0 the next cycle (invalidated), then the new pattern one cycle later.
- Stall/out-of-range: `Req_SI` = 0 for 3 cycles mid-stream → Valid = 0 and no reads. `Addr_DI` = 220 → Valid stays 0 indefinitely.
- Reset: assert `Reset_RBI` asynchronously mid-stream. Required: Valid = 0 immediately; after release, row contents persist and the next request is a cold miss.
